// File: rtl/banked_sp_ram_if.sv
// Request/response bundle for banked_sp_ram: valid/ready request channel plus read-response strobe.
// Master drives requests; slave returns ready and read data with its strobe.
interface banked_sp_ram_if #(
  parameter int WCOUNT  = 256,
  parameter int WLENGTH = 4
);
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_we;
  logic [$clog2(WCOUNT)-1:0]  req_addr;
  logic [WLENGTH-1:0]         req_wdata;
  logic                       rsp_valid;
  logic [WLENGTH-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/banked_sp_ram.sv
// Banked single-port SRAM with post-reset clear engine; optional stuck-at read fault via SRAM_FAULT_INJ_EN.
// Reads return 2 cycles after acceptance; req_ready is low only while the clear engine runs.
module banked_sp_ram #(
  parameter int                 WCOUNT   = 256,
  parameter int                 WLENGTH  = 4,
  parameter int                 NBANKS   = 4,
  parameter logic [WLENGTH-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  banked_sp_ram_if.slave      bus,
  output logic                init_busy
`ifdef SRAM_FAULT_INJ_EN
  ,
  input  logic                                        flt_en,
  input  logic [$clog2(WCOUNT)-1:0]                   flt_addr,
  input  logic [((WLENGTH > 1) ? $clog2(WLENGTH) : 1)-1:0] flt_bit,
  input  logic                                        flt_val
`endif
);

  localparam int ROWS = WCOUNT / NBANKS;
  localparam int BW   = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [RW-1:0]      r_row_cnt;
  logic [RW-1:0]      w_row_cnt_nxt;
  logic               w_init_we;
  logic               w_acc;
  logic [BW-1:0]      w_req_bank;
  logic [RW-1:0]      w_req_row;

  logic               r_s1_vld;
  logic               r_s1_we;
  logic [BW-1:0]      r_s1_bank;
  logic [RW-1:0]      r_s1_row;
  logic [WLENGTH-1:0] r_s1_wdata;

  logic               r_rsp_vld;
  logic [WLENGTH-1:0] r_rsp_rdata;
  logic [WLENGTH-1:0] w_bank_rd [NBANKS];
  logic [WLENGTH-1:0] w_rd_raw;
  logic [WLENGTH-1:0] w_rd_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_INIT;
      r_row_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_cnt <= w_row_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_row_cnt_nxt = r_row_cnt;
    w_init_we     = 1'b0;
    bus.req_ready = 1'b0;
    init_busy     = 1'b0;
    case (r_state)
      S_INIT: begin
        init_busy = 1'b1;
        w_init_we = 1'b1;
        if (r_row_cnt == LAST_ROW) begin
          w_state_nxt = S_RUN;
        end else begin
          w_row_cnt_nxt = r_row_cnt + 1'b1;
        end
      end
      S_RUN: begin
        bus.req_ready = 1'b1;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // Power-of-two geometry: these reduce to plain MSB/LSB slices of the address.
  assign w_acc      = bus.req_valid && bus.req_ready;
  assign w_req_bank = BW'(bus.req_addr / ROWS);
  assign w_req_row  = RW'(bus.req_addr % ROWS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_we    <= 1'b0;
      r_s1_bank  <= '0;
      r_s1_row   <= '0;
      r_s1_wdata <= '0;
    end else begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_we    <= bus.req_we;
        r_s1_bank  <= w_req_bank;
        r_s1_row   <= w_req_row;
        r_s1_wdata <= bus.req_wdata;
      end
    end
  end

  // Storage carries no reset; only the clear engine defines its contents.
  genvar gb;
  for (gb = 0; gb < NBANKS; gb++) begin : g_bank
    logic [WLENGTH-1:0] r_mem [ROWS];

    always_ff @(posedge clk) begin
      if (w_init_we) begin
        r_mem[r_row_cnt] <= INIT_VAL;
      end else if (r_s1_vld && r_s1_we && (r_s1_bank == BW'(gb))) begin
        r_mem[r_s1_row] <= r_s1_wdata;
      end
    end

    assign w_bank_rd[gb] = r_mem[r_s1_row];
  end

  assign w_rd_raw = w_bank_rd[r_s1_bank];

`ifdef SRAM_FAULT_INJ_EN
  logic [BW-1:0] w_flt_bank;
  logic [RW-1:0] w_flt_row;

  assign w_flt_bank = BW'(flt_addr / ROWS);
  assign w_flt_row  = RW'(flt_addr % ROWS);

  // The stuck-at only overrides the returned word; the stored cell is left intact.
  always_comb begin
    w_rd_dat = w_rd_raw;
    if (flt_en && (w_flt_bank == r_s1_bank) && (w_flt_row == r_s1_row) &&
        (int'(flt_bit) < WLENGTH)) begin
      w_rd_dat[flt_bit] = flt_val;
    end
  end
`else
  assign w_rd_dat = w_rd_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_vld   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_vld <= r_s1_vld && !r_s1_we;
      if (r_s1_vld && !r_s1_we) begin
        r_rsp_rdata <= w_rd_dat;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_vld;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_banked_sp_ram.sv
// Scoreboard bench for banked_sp_ram: array model plus expected-response queue checked by a monitor.
module tb_banked_sp_ram;
  localparam int WCOUNT  = 256;
  localparam int WLENGTH = 4;
  localparam int NBANKS  = 4;
  localparam int ROWS    = WCOUNT / NBANKS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic init_busy;

  banked_sp_ram_if #(.WCOUNT(WCOUNT), .WLENGTH(WLENGTH)) bus();

`ifdef SRAM_FAULT_INJ_EN
  logic       flt_en   = 1'b0;
  logic [7:0] flt_addr = 8'h00;
  logic [1:0] flt_bit  = 2'd0;
  logic       flt_val  = 1'b0;
`endif

  banked_sp_ram #(
    .WCOUNT(WCOUNT), .WLENGTH(WLENGTH), .NBANKS(NBANKS), .INIT_VAL(4'h0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .init_busy (init_busy)
`ifdef SRAM_FAULT_INJ_EN
    ,
    .flt_en    (flt_en),
    .flt_addr  (flt_addr),
    .flt_bit   (flt_bit),
    .flt_val   (flt_val)
`endif
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [WLENGTH-1:0] d;
    int                 due;
  } exp_t;

  logic [WLENGTH-1:0] model [WCOUNT];
  exp_t               sb [$];

  function automatic void check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endfunction

  function automatic logic [WLENGTH-1:0] expected_read(input logic [7:0] addr);
    logic [WLENGTH-1:0] d;
    d = model[addr];
`ifdef SRAM_FAULT_INJ_EN
    if (flt_en && flt_addr == addr) d[flt_bit] = flt_val;
`endif
    return d;
  endfunction

  // Response checker: every read response must match the front of the queue, on its due edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due < edge_cnt) begin
        check("rsp_missing_due_edge", edge_cnt, sb[0].due);
        void'(sb.pop_front());
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_data", bus.rsp_rdata, e.d);
          check("rsp_latency_edge", edge_cnt, e.due);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [7:0] addr, input logic [WLENGTH-1:0] wd);
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    if (bus.req_ready) begin
      if (we) begin
        model[addr] = wd;
      end else begin
        e.d   = expected_read(addr);
        e.due = edge_cnt + 2;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < WCOUNT; i++) model[i] = 4'h0;
  endtask

  // Optionally offers a write to 0x10 the whole time the clear engine runs; it must be ignored.
  task automatic wait_init(input bit junk);
    int e0;
    int bad;
    int guard;
    e0    = edge_cnt;
    bad   = 0;
    guard = 0;
    if (junk) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 8'h10;
      bus.req_wdata = 4'hF;
    end
    while (init_busy && guard < 300) begin
      if (bus.req_ready) bad++;
      @(negedge clk);
      guard++;
    end
    bus.req_valid = 1'b0;
    check("init_busy_edges", edge_cnt - e0, ROWS);
    check("ready_during_init", bad, 0);
    check("ready_after_init", bus.req_ready, 1);
  endtask

  task automatic do_reset(input int abort_after, input bit junk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    clear_model();
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_init_busy", init_busy, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    if (abort_after > 0) begin
      repeat (abort_after) @(negedge clk);
      check("busy_mid_init", init_busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    wait_init(junk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gd;
    logic [7:0] ra;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 4'h0;

    do_reset(0, 1'b1);

    issue(1'b0, 8'hA7, 4'h0);
    issue(1'b1, 8'h00, 4'h5);
    issue(1'b0, 8'h00, 4'h0);
    idle(3);

    issue(1'b1, 8'h3F, 4'h1);
    issue(1'b1, 8'h40, 4'h2);
    issue(1'b1, 8'h80, 4'h3);
    issue(1'b1, 8'hFF, 4'h4);
    issue(1'b0, 8'h3F, 4'h0);
    issue(1'b0, 8'h40, 4'h0);
    issue(1'b0, 8'h80, 4'h0);
    issue(1'b0, 8'hFF, 4'h0);
    issue(1'b0, 8'h10, 4'h0);
    idle(4);

    for (int i = 0; i < 400; i++) begin
      ra = ($urandom % 2 == 0) ? 8'($urandom % 16) : 8'($urandom);
      if ($urandom % 5 == 0) idle(1);
      else issue(1'($urandom), ra, 4'($urandom));
    end
    idle(4);

    // Reset mid-run with reads in flight: response must drop at once and INIT reruns.
    issue(1'b1, 8'h55, 4'h9);
    issue(1'b0, 8'h55, 4'h0);
    issue(1'b0, 8'h3F, 4'h0);
    issue(1'b0, 8'h40, 4'h0);
    issue(1'b0, 8'h80, 4'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #2;
    check("rsp_valid_before_reset", bus.rsp_valid, 1);
    rst_n = 1'b0;
    clear_model();
    #1;
    check("rsp_valid_drops_on_reset", bus.rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(1'b0);
    issue(1'b0, 8'h55, 4'h0);
    issue(1'b0, 8'h00, 4'h0);

    // Reset again 20 cycles into INIT: full clear must restart.
    issue(1'b1, 8'h55, 4'h9);
    issue(1'b0, 8'h55, 4'h0);
    idle(4);
    do_reset(20, 1'b0);
    issue(1'b0, 8'h55, 4'h0);
    issue(1'b0, 8'hFF, 4'h0);
    idle(4);

`ifdef SRAM_FAULT_INJ_EN
    issue(1'b1, 8'h22, 4'hF);
    issue(1'b1, 8'h23, 4'hF);
    idle(1);
    flt_en   = 1'b1;
    flt_addr = 8'h22;
    flt_bit  = 2'd2;
    flt_val  = 1'b0;
    issue(1'b0, 8'h22, 4'h0);
    issue(1'b0, 8'h23, 4'h0);
    issue(1'b0, 8'h22, 4'h0);
    idle(4);
    flt_en = 1'b0;
    issue(1'b0, 8'h22, 4'h0);
    idle(4);
    flt_en  = 1'b1;
    flt_bit = 2'd0;
    flt_val = 1'b1;
    issue(1'b1, 8'h22, 4'h4);
    issue(1'b0, 8'h22, 4'h0);
    idle(4);
    flt_en = 1'b0;
    issue(1'b0, 8'h22, 4'h0);
    idle(4);
`endif

    gd = 0;
    while (sb.size() > 0 && gd < 20) begin
      @(negedge clk);
      gd++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/banked_sp_ram.md
# banked_sp_ram

Parametrised, banked single-port SRAM for the MBIST test path. Words split across `NBANKS` equal banks on the address MSBs. Requests and reads pass through a registered 2-stage pipeline with a valid/ready request interface and a read-response valid strobe. A post-reset clear engine writes `INIT_VAL` to every word before the first request is accepted, so the MBIST controller always starts from known contents.

## Interface
- `WCOUNT`, 256, total words; power of 2, ≥ `NBANKS`
- `WLENGTH`, 4, bits per word, ≥1
- `NBANKS`, 4, bank count; power of 2, 1..`WCOUNT`
- `INIT_VAL`, 0, `WLENGTH`-bit value written to every word by the clear engine
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block accepts a request this cycle
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  $clog2(WCOUNT)  word address
- `req_wdata`  in  WLENGTH  write data
- `rsp_valid`  out  1  `rsp_rdata` carries a read result this cycle
- `rsp_rdata`  out  WLENGTH  read data
- `init_busy`  out  1  clear engine running

## Operation
- Address split: bank = top $clog2(NBANKS) bits of `req_addr`; row = remaining low bits. With `NBANKS`=1 the whole address is the row.
- FSM states:
  - INIT: row counter walks 0..WCOUNT/NBANKS-1 and writes `INIT_VAL` to that row in all banks in parallel. `init_busy`=1, `req_ready`=0.
  - RUN: `req_ready`=1 every cycle; a new request can be accepted every cycle.
- INIT→RUN after the last row is written (counter = WCOUNT/NBANKS-1). RUN is never left except via reset.
- Handshake: a request is accepted on an edge where `req_valid`&&`req_ready`. Requests presented while `req_ready`=0 are ignored, not queued.
- Stage 1: register we, bank, row, wdata and a valid bit.
- Stage 2, write: update the selected bank/row.
- Stage 2, read: register the selected bank/row into `rsp_rdata` and set `rsp_valid`.
- Writes never produce a response.
- Requests complete in acceptance order. A read accepted one edge after a write to the same address returns the new data, with no forwarding logic needed.
- `rsp_rdata` holds its last value while `rsp_valid`=0.
- Array contents are not touched by reset itself; only INIT defines them.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `init_busy`=1, FSM=INIT, row counter=0, pipeline valid bits=0.
- First INIT write occurs on the first rising edge after `rst_n` deasserts. `init_busy` falls (and `req_ready` rises) after exactly WCOUNT/NBANKS edges: 64 for the defaults.
- Read accepted at edge N: `rsp_valid`=1 with data during the cycle after edge N+1, i.e. 2-cycle latency.
- Write accepted at edge N: array updated at edge N+1.
- Back-to-back reads: one `rsp_valid` pulse per read, no gaps.
- Reset asserted mid-INIT: counter returns to 0 and INIT restarts from row 0.
- Reset asserted mid-RUN: in-flight requests are dropped (a pending write may or may not land), `rsp_valid` drops immediately, then the full INIT reruns.
- Addresses are always in range by width; no error path.

## Configuration
- `SRAM_FAULT_INJ_EN` defined: adds inputs `flt_en` (1), `flt_addr` ($clog2(WCOUNT)), `flt_bit` ($clog2(WLENGTH), min 1), `flt_val` (1).
  - When `flt_en`=1, any read of `flt_addr` returns bit `flt_bit` forced to `flt_val`, modelling a stuck-at cell for MBIST fault detection.
  - The fault ports are sampled with the read in stage 2. The stored array is never modified.
- Not defined: ports absent, read path unmodified.

## Test plan
- Reset release, defaults → `init_busy`=1 and `req_ready`=0 for 64 cycles, then `req_ready`=1. A read of address 0xA7 returns 0x0 with `rsp_valid` 2 cycles after acceptance.
- Write 0x5 to address 0x00, then read 0x00 on the next cycle → `rsp_rdata`=0x5 exactly 2 cycles after the read is accepted.
- Write distinct values to 0x3F, 0x40, 0x80, 0xFF (one per bank boundary), then 4 back-to-back reads → 4 consecutive `rsp_valid` cycles with matching data in order.
- Assert `rst_n` low at cycle 20 of INIT → counter restarts. `init_busy` stays 1 for a further 64 cycles after release, and a previously written word reads 0x0.
- `req_valid`=1 write of 0xF to 0x10 during INIT → not accepted. A read of 0x10 after INIT returns 0x0.
- With `SRAM_FAULT_INJ_EN`: write 0xF to 0x22, set `flt_en`=1, `flt_addr`=0x22, `flt_bit`=2, `flt_val`=0 → read returns 0xB. With `flt_en`=0 the same read returns 0xF.
